// File: rtl/calculator_pkg.sv
// Shared types for the calculator datapath and its command sequencer front end.
package calculator_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } te_operation;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_OVERFLOW  = 2'd1,
        STATUS_UNDERFLOW = 2'd2
    } te_out_status;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } te_seq_state;

    localparam int OP_W = $bits(te_operation);

    // Width of one packed {a, b, op} command word.
    function automatic int cmd_width(input int bit_width);
        return 2 * bit_width + OP_W;
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Circular command buffer; reset clears pointers and count, storage is left as-is.
module calc_cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Buffers calculator commands, issues them one at a time, holds operands for the
// calculator latency and returns captured result/status in acceptance order.
module calc_cmd_sequencer
    import calculator_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CALC_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [BIT_WIDTH-1:0] cmd_a,
    input  logic [BIT_WIDTH-1:0] cmd_b,
    input  te_operation          cmd_op,
    output logic [BIT_WIDTH-1:0] calc_a,
    output logic [BIT_WIDTH-1:0] calc_b,
    output te_operation          calc_operation,
    input  logic [BIT_WIDTH-1:0] calc_result,
    input  te_out_status         calc_status,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_result,
    output te_out_status         rsp_status,
    output logic                 busy
);

    localparam int CMD_W = cmd_width(BIT_WIDTH);
    localparam int CNT_W = (CALC_LATENCY < 2) ? 1 : $clog2(CALC_LATENCY + 1);

    logic [CMD_W-1:0]              push_data;
    logic [CMD_W-1:0]              head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          push;
    logic                          pop;
    te_seq_state                   state;
    logic [CNT_W-1:0]              counter;

    // Ready follows the registered full flag only, so a same-cycle pop never frees a slot.
    assign cmd_ready = !fifo_full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign push_data = {cmd_a, cmd_b, cmd_op};
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    calc_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            calc_a         <= '0;
            calc_b         <= '0;
            calc_operation <= te_operation'('0);
            rsp_valid      <= 1'b0;
            rsp_result     <= '0;
            rsp_status     <= te_out_status'('0);
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        calc_a         <= head[CMD_W-1 -: BIT_WIDTH];
                        calc_b         <= head[OP_W +: BIT_WIDTH];
                        calc_operation <= te_operation'(head[OP_W-1:0]);
                        counter        <= CNT_W'(CALC_LATENCY);
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        rsp_result <= calc_result;
                        rsp_status <= calc_status;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer: latency-2 instance with scoreboard, plus a
// combinational-calculator instance for the zero-latency timing.
module tb_calc_cmd_sequencer;
    import calculator_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // latency-2 instance
    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [W-1:0] cmd_a, cmd_b, calc_a, calc_b, calc_result, rsp_result;
    te_operation  cmd_op, calc_operation;
    te_out_status calc_status, rsp_status;

    // latency-0 instance
    logic         z_cmd_valid, z_cmd_ready, z_rsp_valid, z_rsp_ready, z_busy;
    logic [W-1:0] z_cmd_a, z_cmd_b, z_calc_a, z_calc_b, z_calc_result, z_rsp_result;
    te_operation  z_cmd_op, z_calc_operation;
    te_out_status z_calc_status, z_rsp_status;

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_v;

    calc_cmd_sequencer #(.BIT_WIDTH(W), .FIFO_DEPTH(4), .CALC_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .calc_a(calc_a), .calc_b(calc_b), .calc_operation(calc_operation),
        .calc_result(calc_result), .calc_status(calc_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_status(rsp_status), .busy(busy)
    );

    calc_cmd_sequencer #(.BIT_WIDTH(W), .FIFO_DEPTH(4), .CALC_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready),
        .cmd_a(z_cmd_a), .cmd_b(z_cmd_b), .cmd_op(z_cmd_op),
        .calc_a(z_calc_a), .calc_b(z_calc_b), .calc_operation(z_calc_operation),
        .calc_result(z_calc_result), .calc_status(z_calc_status),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_result(z_rsp_result),
        .rsp_status(z_rsp_status), .busy(z_busy)
    );

    // Reference calculator: returns {status, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input te_operation op);
        logic [W:0]   s;
        logic [W-1:0] r;
        te_out_status st;
        st = STATUS_OK;
        s  = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                if (s[W]) st = STATUS_OVERFLOW;
            end
            OP_SUB: begin
                r = a - b;
                if (a < b) st = STATUS_UNDERFLOW;
            end
            OP_AND:  r = a & b;
            default: r = a | b;
        endcase
        return {st, r};
    endfunction

    // Calculator stand-ins: two-stage pipeline for dut, combinational for dut0.
    logic [W+1:0] calc_p1, calc_p2, z_calc_out;
    always @(posedge clk) begin
        calc_p1 <= model(calc_a, calc_b, calc_operation);
        calc_p2 <= calc_p1;
    end
    assign calc_result   = calc_p2[W-1:0];
    assign calc_status   = te_out_status'(calc_p2[W+1:W]);
    assign z_calc_out    = model(z_calc_a, z_calc_b, z_calc_operation);
    assign z_calc_result = z_calc_out[W-1:0];
    assign z_calc_status = te_out_status'(z_calc_out[W+1:W]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input te_operation op);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("send_accept", done, 1);
        if (done) exp_q.push_back(model(a, b, op));
    endtask

    task automatic wait_rsp_valid(input string tag);
        for (int i = 0; i < 50 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, rsp_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (busy || rsp_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, busy || rsp_valid, 0);
    endtask

    // Response monitor: a handshake seen at the negedge completes at the next rising edge.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready && !reset) begin
            check("rsp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_v = exp_q.pop_front();
                check("rsp_result", rsp_result, mon_v[W-1:0]);
                check("rsp_status", rsp_status, mon_v[W+1:W]);
                rsp_count++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        bit stable;
        bit seen;
        logic [W-1:0] snap_r, snap_a, snap_b;
        te_out_status snap_s;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = OP_ADD; rsp_ready = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_a = '0; z_cmd_b = '0; z_cmd_op = OP_ADD; z_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_calc_a", calc_a, 0);
        check("rst_calc_b", calc_b, 0);
        check("rst_calc_op", calc_operation, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_status", rsp_status, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", cmd_ready, 1);

        // 1: latency and operand hold, ADD 1+3
        send(8'd1, 8'd3, OP_ADD);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            check("t1_calc_a", calc_a, 1);
            check("t1_calc_b", calc_b, 3);
        end
        check("t1_latency", n, 4);
        check("t1_result", rsp_result, 4);
        rsp_ready = 1'b1;
        wait_idle("t1_idle");

        // 2: fill the FIFO with responses stalled, then drain in order
        rsp_ready = 1'b0;
        base = rsp_count;
        send(8'd8, 8'd16, OP_ADD);
        send(8'd1, 8'd1, OP_ADD);
        send(8'd0, 8'd0, OP_ADD);
        send(8'd1, 8'd0, OP_ADD);
        send(8'd2, 8'd2, OP_ADD);
        check("t2_full_ready", cmd_ready, 0);
        check("t2_busy", busy, 1);
        cmd_valid = 1'b1; cmd_a = 8'd5; cmd_b = 8'd5; cmd_op = OP_ADD;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t2_stall", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        send(8'd5, 8'd5, OP_ADD);
        wait_idle("t2_idle");
        check("t2_rsp_count", rsp_count - base, 6);

        // 3: backpressure holds response and blocks the next issue
        rsp_ready = 1'b0;
        send(8'd10, 8'd20, OP_ADD);
        send(8'd3, 8'd4, OP_ADD);
        wait_rsp_valid("t3_rsp_valid");
        snap_r = rsp_result; snap_s = rsp_status; snap_a = calc_a; snap_b = calc_b;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_result !== snap_r || rsp_status !== snap_s ||
                calc_a !== snap_a || calc_b !== snap_b) stable = 1'b0;
        end
        check("t3_stable", stable, 1);
        check("t3_result", rsp_result, 30);
        check("t3_calc_a", calc_a, 10);
        rsp_ready = 1'b1;
        wait_idle("t3_idle");

        // 4: wrap-around and status pass-through
        rsp_ready = 1'b0;
        send(8'd255, 8'd1, OP_ADD);
        wait_rsp_valid("t4_rsp_valid");
        check("t4_result", rsp_result, 0);
        check("t4_status", rsp_status, STATUS_OVERFLOW);
        rsp_ready = 1'b1;
        send(8'd3, 8'd5, OP_SUB);
        send(8'd12, 8'd10, OP_AND);
        send(8'd12, 8'd3, OP_OR);
        wait_idle("t4_idle");

        // 5a: reset while a response is pending drops rsp_valid asynchronously
        rsp_ready = 1'b0;
        send(8'd9, 8'd9, OP_ADD);
        wait_rsp_valid("t5a_rsp_valid");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5a_async_valid", rsp_valid, 0);
        check("t5a_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();

        // 5b: reset in WAIT with three commands queued
        @(posedge clk);
        #1;
        send(8'd1, 8'd1, OP_ADD);
        send(8'd2, 8'd3, OP_ADD);
        send(8'd4, 8'd5, OP_ADD);
        send(8'd6, 8'd7, OP_ADD);
        check("t5b_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("t5b_rsp_valid", rsp_valid, 0);
        check("t5b_busy", busy, 0);
        check("t5b_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rsp_ready = 1'b1;
        base = rsp_count;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("t5b_no_rsp", seen, 0);
        send(8'd2, 8'd2, OP_ADD);
        wait_idle("t5b_idle");
        check("t5b_rsp_count", rsp_count - base, 1);

        // 6: zero-latency instance, ADD 7+9
        z_cmd_valid = 1'b1; z_cmd_a = 8'd7; z_cmd_b = 8'd9; z_cmd_op = OP_ADD;
        @(negedge clk);
        check("t6_ready", z_cmd_ready, 1);
        @(posedge clk);
        #1;
        z_cmd_valid = 1'b0;
        n = 0;
        while (!z_rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_latency", n, 2);
        check("t6_result", z_rsp_result, 16);
        check("t6_status", z_rsp_status, STATUS_OK);
        check("t6_calc_a", z_calc_a, 7);
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t6_release", z_rsp_valid, 0);
        z_rsp_ready = 1'b0;

        // random commands with responses always accepted
        rsp_ready = 1'b1;
        base = rsp_count;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 te_operation'($urandom_range(0, 3)));
        end
        wait_idle("rand_idle");
        check("rand_rsp_count", rsp_count - base, 8);
        check("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
